// File: rtl/cork_refill_loader_pkg.sv
// Shared types and defaults for the cork refill loader.
// Imported by the loader top and its bench.
package cork_refill_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_WIDTH     = 7;
    localparam int DEF_BATCH_MAX = 100;
    localparam int DEF_HOLD_MAX  = 4;

endpackage

// File: rtl/cork_sensor_sync.sv
// Two-flop synchroniser for the hopper sensor plus a rising-edge
// detector giving one event cycle per cork.
module cork_sensor_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cork_i,
    output logic cork_evt_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], cork_i};
        end
    end

    // sync_q[2] only remembers the previous synchronised level
    assign cork_evt_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cork_refill_loader.sv
// Accumulates hopper corks and parallel-loads the batch into the
// cork down-counter whenever that counter reports empty.
module cork_refill_loader
    import cork_refill_loader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BATCH_MAX = DEF_BATCH_MAX,
    parameter int HOLD_MAX  = DEF_HOLD_MAX
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             CorkIn,
    input  logic             Empty,
    output logic [WIDTH-1:0] P,
    output logic             PLoad,
    output logic [WIDTH-1:0] Stock,
    output logic             Full,
    output logic             Overflow,
    output logic             Fault
);

    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [WIDTH-1:0] BMAX  = WIDTH'(BATCH_MAX);
    localparam logic [CW-1:0]    HLAST = CW'(HOLD_MAX - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  stock_q, stock_d;
    logic [WIDTH-1:0]  p_q, p_d;
    logic              pload_q, pload_d;
    logic              ovf_q, ovf_d;
    logic              fault_q, fault_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cork_evt;

    cork_sensor_sync u_sync (
        .clk_i      (CLK),
        .rst_ni     (Reset_n),
        .cork_i     (CorkIn),
        .cork_evt_o (cork_evt)
    );

    always_comb begin
        state_d = state_q;
        stock_d = stock_q;
        p_d     = p_q;
        pload_d = 1'b1;
        ovf_d   = ovf_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        if (cork_evt) begin
            if (stock_q != BMAX) begin
                stock_d = stock_q + 1'b1;
            end else if (state_q != LOAD) begin
                ovf_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (Empty && (stock_q != '0)) begin
                    state_d = LOAD;
                    p_d     = stock_d;
                    pload_d = 1'b0;
                end
            end
            LOAD: begin
                // a cork arriving during the transfer starts the next batch
                stock_d = WIDTH'(cork_evt);
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (!Empty) begin
                    state_d = IDLE;
                end else if (cnt_q == HLAST) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            stock_q <= '0;
            p_q     <= '0;
            pload_q <= 1'b1;
            ovf_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stock_q <= stock_d;
            p_q     <= p_d;
            pload_q <= pload_d;
            ovf_q   <= ovf_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign P        = p_q;
    assign PLoad    = pload_q;
    assign Stock    = stock_q;
    assign Full     = (stock_q == BMAX);
    assign Overflow = ovf_q;
    assign Fault    = fault_q;

endmodule

// File: tb/tb_cork_refill_loader.sv
// Bench for cork_refill_loader: directed scenarios plus a random
// cork/Empty run scored against a cycle-level stock model.
`timescale 1ns/1ps
module tb_cork_refill_loader;

    localparam int W    = 7;
    localparam int BMAX = 100;
    localparam int HMAX = 4;

    logic         CLK = 1'b0;
    logic         Reset_n = 1'b0;
    logic         CorkIn = 1'b0;
    logic         Empty = 1'b0;
    logic [W-1:0] P;
    logic         PLoad;
    logic [W-1:0] Stock;
    logic         Full;
    logic         Overflow;
    logic         Fault;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    cork_refill_loader #(
        .WIDTH     (W),
        .BATCH_MAX (BMAX),
        .HOLD_MAX  (HMAX)
    ) dut (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .CorkIn   (CorkIn),
        .Empty    (Empty),
        .P        (P),
        .PLoad    (PLoad),
        .Stock    (Stock),
        .Full     (Full),
        .Overflow (Overflow),
        .Fault    (Fault)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // one cork: sensor high two cycles, low two cycles
    task automatic send_corks(input int n);
        repeat (n) begin
            CorkIn = 1'b1;
            tick();
            tick();
            CorkIn = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic drain();
        Empty = 1'b1;
        tick();
        tick();
        Empty = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        tests++; if (PLoad !== 1'b1) begin fails++; $display("FAIL reset_pload: got %b want 1", PLoad); end
        tests++; if (P !== 7'd0) begin fails++; $display("FAIL reset_p: got %0d want 0", P); end
        tests++; if (Stock !== 7'd0) begin fails++; $display("FAIL reset_stock: got %0d want 0", Stock); end
        tests++; if (Full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", Full); end
        tests++; if (Overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", Overflow); end
        tests++; if (Fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", Fault); end
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load37();
        int strobes;
        send_corks(37);
        tests++; if (Stock !== 7'd37) begin fails++; $display("FAIL l37_stock: got %0d want 37", Stock); end
        Empty = 1'b1;
        tick();
        tests++; if (PLoad !== 1'b0) begin fails++; $display("FAIL l37_strobe: got %b want 0", PLoad); end
        tests++; if (P !== 7'd37) begin fails++; $display("FAIL l37_p: got %0d want 37", P); end
        tick();
        tests++; if (PLoad !== 1'b1) begin fails++; $display("FAIL l37_strobe_end: got %b want 1", PLoad); end
        tests++; if (Stock !== 7'd0) begin fails++; $display("FAIL l37_clear: got %0d want 0", Stock); end
        Empty = 1'b0;
        strobes = 0;
        repeat (6) begin
            tick();
            if (PLoad === 1'b0) strobes++;
        end
        tests++; if (strobes != 0) begin fails++; $display("FAIL l37_extra: got %0d strobes want 0", strobes); end
        tests++; if (P !== 7'd37) begin fails++; $display("FAIL l37_p_hold: got %0d want 37", P); end
        tests++; if (Fault !== 1'b0) begin fails++; $display("FAIL l37_fault: got %b want 0", Fault); end
    endtask

    task automatic test_coincident();
        send_corks(10);
        CorkIn = 1'b1;
        tick();
        Empty = 1'b1;
        tick();
        CorkIn = 1'b0;
        tests++; if (PLoad !== 1'b0) begin fails++; $display("FAIL coin_strobe: got %b want 0", PLoad); end
        tests++; if (P !== 7'd10) begin fails++; $display("FAIL coin_p: got %0d want 10", P); end
        tick();
        tests++; if (Stock !== 7'd1) begin fails++; $display("FAIL coin_stock: got %0d want 1", Stock); end
        Empty = 1'b0;
        tick();
        tick();
        drain();
        tests++; if (P !== 7'd1) begin fails++; $display("FAIL coin_reload: got %0d want 1", P); end
        tests++; if (Stock !== 7'd0) begin fails++; $display("FAIL coin_drain: got %0d want 0", Stock); end
    endtask

    task automatic test_saturation();
        send_corks(BMAX);
        tests++; if (Stock !== 7'(BMAX)) begin fails++; $display("FAIL sat_stock100: got %0d want %0d", Stock, BMAX); end
        tests++; if (Full !== 1'b1) begin fails++; $display("FAIL sat_full: got %b want 1", Full); end
        tests++; if (Overflow !== 1'b0) begin fails++; $display("FAIL sat_ovf_early: got %b want 0", Overflow); end
        send_corks(2);
        tests++; if (Stock !== 7'(BMAX)) begin fails++; $display("FAIL sat_nowrap: got %0d want %0d", Stock, BMAX); end
        tests++; if (Overflow !== 1'b1) begin fails++; $display("FAIL sat_ovf: got %b want 1", Overflow); end
        Empty = 1'b1;
        tick();
        tests++; if (PLoad !== 1'b0) begin fails++; $display("FAIL sat_strobe: got %b want 0", PLoad); end
        tests++; if (P !== 7'(BMAX)) begin fails++; $display("FAIL sat_p: got %0d want %0d", P, BMAX); end
        tick();
        Empty = 1'b0;
        tests++; if (Full !== 1'b0) begin fails++; $display("FAIL sat_full_clr: got %b want 0", Full); end
        tests++; if (Overflow !== 1'b1) begin fails++; $display("FAIL sat_ovf_sticky: got %b want 1", Overflow); end
        tick();
        tick();
    endtask

    task automatic test_fault();
        int early;
        int strobes;
        send_corks(8);
        Empty = 1'b1;
        tick();
        tests++; if (PLoad !== 1'b0 || P !== 7'd8) begin fails++; $display("FAIL flt_load: got pload=%b p=%0d want 0/8", PLoad, P); end
        early = 0;
        repeat (HMAX) begin
            tick();
            if (Fault !== 1'b0 || PLoad !== 1'b1) early++;
        end
        tests++; if (early != 0) begin fails++; $display("FAIL flt_early: got %0d bad hold cycles want 0", early); end
        tick();
        tests++; if (Fault !== 1'b1) begin fails++; $display("FAIL flt_set: got %b want 1", Fault); end
        strobes = 0;
        repeat (10) begin
            tick();
            if (PLoad === 1'b0) strobes++;
        end
        tests++; if (strobes != 0) begin fails++; $display("FAIL flt_empty_nostock: got %0d strobes want 0", strobes); end
        tests++; if (Fault !== 1'b1) begin fails++; $display("FAIL flt_sticky: got %b want 1", Fault); end
        Empty = 1'b0;
        tick();
    endtask

    // stock model: each cork lands 3 edges after its rise and saturates
    // at BMAX; the edge after a strobe restarts the batch from zero
    task automatic test_random();
        int pend[$];
        int mstock = 0;
        int sent = 0;
        int sum_p = 0;
        int cyc = 0;
        int last = -100;
        int nstrobe = 0;
        int hi_left = 0;
        int lo_left = 2;
        bit prev_low = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (CorkIn) begin
                hi_left--;
                if (hi_left == 0) begin
                    CorkIn = 1'b0;
                    lo_left = $urandom_range(2, 5);
                end
            end else if (lo_left > 0) begin
                lo_left--;
            end else if (i < 360) begin
                CorkIn = 1'b1;
                hi_left = $urandom_range(2, 3);
                sent++;
                pend.push_back(cyc + 3);
            end
            if ($urandom_range(0, 3) == 0) Empty = ~Empty;
            tick();
            cyc++;
            if (prev_low) mstock = 0;
            while (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                if (mstock < BMAX) mstock++;
            end
            tests++;
            if (Stock !== 7'(mstock)) begin
                fails++;
                $display("FAIL rnd_stock@%0d: got %0d want %0d", cyc, Stock, mstock);
            end
            if (PLoad === 1'b0) begin
                nstrobe++;
                tests++;
                if (P !== 7'(mstock) || mstock == 0) begin
                    fails++;
                    $display("FAIL rnd_p@%0d: got %0d want %0d", cyc, P, mstock);
                end
                tests++;
                if (cyc - last < 3) begin
                    fails++;
                    $display("FAIL rnd_spacing@%0d: got %0d want >=3", cyc, cyc - last);
                end
                sum_p += mstock;
                last = cyc;
            end
            prev_low = (PLoad === 1'b0);
        end
        CorkIn = 1'b0;
        Empty = 1'b0;
        tick();
        tick();
        tests++; if (nstrobe == 0) begin fails++; $display("FAIL rnd_no_loads: got 0 strobes want >0"); end
        tests++;
        if (sum_p + int'(Stock) != sent) begin
            fails++;
            $display("FAIL rnd_conserve: got %0d corks want %0d", sum_p + int'(Stock), sent);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send_corks(5);
        tests++; if (Stock !== 7'd5) begin fails++; $display("FAIL rmid_stock: got %0d want 5", Stock); end
        Empty = 1'b1;
        tick();
        tests++; if (PLoad !== 1'b0 || P !== 7'd5) begin fails++; $display("FAIL rmid_load: got pload=%b p=%0d want 0/5", PLoad, P); end
        Reset_n = 1'b0;
        #1;
        tests++; if (PLoad !== 1'b1) begin fails++; $display("FAIL rmid_pload: got %b want 1", PLoad); end
        tests++; if (P !== 7'd0) begin fails++; $display("FAIL rmid_p: got %0d want 0", P); end
        tests++; if (Stock !== 7'd0) begin fails++; $display("FAIL rmid_stock0: got %0d want 0", Stock); end
        tests++; if (Overflow !== 1'b0 || Fault !== 1'b0 || Full !== 1'b0) begin
            fails++;
            $display("FAIL rmid_flags: got ovf=%b flt=%b full=%b want 0/0/0", Overflow, Fault, Full);
        end
        Empty = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load37();
        test_coincident();
        test_saturation();
        test_fault();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/cork_refill_loader.md
Name: cork_refill_loader

Overview:
- Write side of the cork counter's parallel-load interface.
- Counts corks arriving from the hopper sensor into a saturating stock accumulator.
- When the downstream 7-bit cork down-counter reports empty, transfers the accumulated batch by driving the P word and an active-low PLoad strobe.
- Sits between the hopper sensor and the cork counter in the bottling line.

Parameters:
- WIDTH, 7, width of stock accumulator and P word.
- BATCH_MAX, 100, stock saturation value; must be ≤ 2^WIDTH-1.
- HOLD_MAX, 4, cycles to wait for Empty to drop after a load before flagging Fault.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- CorkIn  input  1  raw hopper sensor, asynchronous; one high pulse (≥2 CLK cycles) per cork.
- Empty  input  1  high when the cork counter output is 0; synchronous to CLK.
- P  output  WIDTH  parallel load word to the cork counter.
- PLoad  output  1  active-low load strobe to the cork counter.
- Stock  output  WIDTH  current accumulated cork count.
- Full  output  1  Stock == BATCH_MAX.
- Overflow  output  1  sticky; a cork arrived while Full.
- Fault  output  1  sticky; Empty still high HOLD_MAX cycles after a load.

Behaviour:
- Reset (async assert, sync release): P=0, PLoad=1, Stock=0, Full=0, Overflow=0, Fault=0, state IDLE, synchroniser flops 0.
- CorkIn passes a 2-flop synchroniser plus a rising-edge detector, producing cork_evt (one cycle per cork). Latency from CorkIn rise to Stock increment is 3 cycles.
- Accumulator:
  - cork_evt and Stock<BATCH_MAX → Stock+1.
  - cork_evt and Stock==BATCH_MAX → Stock unchanged, Overflow←1.
  - No wrap-around, ever.
- FSM states: IDLE, LOAD, HOLD.
  - IDLE: if Empty=1 and Stock≠0 → LOAD. Empty=1 with Stock=0 stays IDLE (nothing to load).
  - LOAD (exactly 1 cycle): P registered ← Stock at state entry; PLoad=0 for this cycle only; Stock cleared at end of cycle. A cork_evt in the same cycle makes Stock=1 after the clear, so the cork is never lost. → HOLD.
  - HOLD: PLoad=1. Count cycles.
    - Empty=0 → IDLE.
    - HOLD_MAX cycles elapse with Empty=1 → Fault←1, then IDLE.
    - Stock keeps accumulating in HOLD.
- P holds its last loaded value outside LOAD; it is valid only while PLoad=0.
- Outputs P and PLoad come straight from flops (no glitches), because the cork counter uses PLoad asynchronously.
- Full is combinational from the Stock register.
- Overflow and Fault clear only on reset.
- Reset during LOAD: PLoad returns to 1 immediately (async). The in-flight batch is lost; Stock=0.
- Empty asserted continuously: after each load→HOLD→IDLE cycle a new load occurs only if Stock≠0. Minimum spacing between PLoad strobes is 3 cycles.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LOAD=2'd1, HOLD=2'd2), default WIDTH, BATCH_MAX.
- One natural sub-module: cork_sensor_sync (2-flop synchroniser + rising-edge pulse). The FSM and accumulator stay in the top.

Test Plan:
- Reset mid-count: 5 corks, assert Reset_n=0 → Stock=0, PLoad=1, P=0, flags 0 with no clock edge.
- 37 corks, then Empty=1 → single PLoad=0 cycle with P=37; Stock=0 next cycle. Empty dropped → IDLE.
- Cork edge coincident with the LOAD cycle, Stock=10 → P=10 and Stock=1 afterwards.
- 102 corks with BATCH_MAX=100 → Stock saturates at 100, Full=1, Overflow=1. Load → P=100, Full=0, Overflow stays 1.
- Empty held high after a load of P=8 → Fault=1 after 4 HOLD cycles; FSM back in IDLE. Empty=1 with Stock=0 → no strobe.
